booth_product_accumulator: RTL and testbench

- Downstream consumer of the 32x32 signed Booth multiplier's registered 64-bit Product.
- Accumulates a programmed number of signed products into a wide accumulator, e.g. for dot-products and FIR taps.
- Presents the result on a valid/ready output handshake.
- Sits between the multiplier's output register and the result bus / next datapath stage.

---
 rtl/booth_pkg.sv | 25 ++
 rtl/booth_acc_adder.sv | 36 +++
 rtl/booth_product_accumulator.sv | 106 ++++++++++
 tb/tb_booth_product_accumulator.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth product accumulator.
// BOOTH_ACC_SAT_EN selects the saturating adder.
package booth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } state_e;

    localparam int unsigned ProdWDef = 64;
    localparam int unsigned AccWDef  = 72;
    localparam int unsigned CntWDef  = 8;
    localparam int unsigned MaxAccW  = 128;

    // Callers truncate these to their own ACC_W.
    function automatic logic [MaxAccW-1:0] sat_max(input int unsigned acc_w);
        return (MaxAccW'(1) << (acc_w - 1)) - MaxAccW'(1);
    endfunction

    function automatic logic [MaxAccW-1:0] sat_min(input int unsigned acc_w);
        return MaxAccW'(1) << (acc_w - 1);
    endfunction

endpackage

// File: rtl/booth_acc_adder.sv
// Sign-extending accumulate adder with signed-overflow detect.
// Defining BOOTH_ACC_SAT_EN clamps the sum on overflow instead of wrapping.
module booth_acc_adder
    import booth_pkg::*;
#(
    parameter int unsigned PROD_W = ProdWDef,
    parameter int unsigned ACC_W  = AccWDef
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] product_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] raw_sum;

`ifdef BOOTH_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SatMax = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SatMin = ACC_W'(sat_min(ACC_W));
`endif

    always_comb begin
        prod_ext = ACC_W'($signed(product_i));
        raw_sum  = acc_i + prod_ext;
        // Overflow only when both operands share a sign and the sum flips it.
        ovf_o = (acc_i[ACC_W-1] == prod_ext[ACC_W-1]) &&
                (raw_sum[ACC_W-1] != acc_i[ACC_W-1]);
`ifdef BOOTH_ACC_SAT_EN
        sum_o = ovf_o ? (acc_i[ACC_W-1] ? SatMin : SatMax) : raw_sum;
`else
        sum_o = raw_sum;
`endif
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Burst accumulator for signed multiplier products with valid/ready result.
// Saturation on overflow is enabled by defining BOOTH_ACC_SAT_EN.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int unsigned PROD_W = ProdWDef,
    parameter int unsigned ACC_W  = AccWDef,
    parameter int unsigned CNT_W  = CntWDef
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PROD_W-1:0] product_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ACC_W-1:0]  result_o,
    output logic              busy_o,
    output logic              overflow_o
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    booth_acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc_i     (acc_q),
        .product_i (product_i),
        .sum_o     (add_sum),
        .ovf_o     (add_ovf)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        // clear outranks both start and a product handshake.
        if (clear_i) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = len_i;
                        state_d = (len_i != '0) ? StRun : StHold;
                    end
                end
                StRun: begin
                    if (in_valid_i) begin
                        acc_d = add_sum;
                        ovf_d = ovf_q | add_ovf;
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (out_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready_o  = (state_q == StRun);
        out_valid_o = (state_q == StHold);
        busy_o      = (state_q == StRun) || (state_q == StHold);
        result_o    = acc_q;
        overflow_o  = ovf_q;
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed scoreboard bench for booth_product_accumulator (ACC_W=72 plus a narrow
// ACC_W=66 twin that shares stimulus so overflow is reachable).
module tb_booth_product_accumulator;

    localparam int unsigned PW  = 64;
    localparam int unsigned AW  = 72;
    localparam int unsigned AWS = 66;
    localparam int unsigned CW  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] len;
    logic          clear;
    logic          in_valid;
    logic [PW-1:0] product;
    logic          out_ready;

    logic          in_ready, out_valid, busy, overflow;
    logic [AW-1:0] result;
    logic          in_ready_s, out_valid_s, busy_s, overflow_s;
    logic [AWS-1:0] result_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0]  r;
        logic           o;
        logic [AWS-1:0] rs;
        logic           os;
    } exp_t;

    exp_t exp_q[$];

    logic signed [127:0] m_acc, m_acc_s;
    logic                m_ovf, m_ovf_s;

    always #5 clk = ~clk;

    booth_product_accumulator #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .len_i       (len),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .product_i   (product),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .busy_o      (busy),
        .overflow_o  (overflow)
    );

    booth_product_accumulator #(.PROD_W(PW), .ACC_W(AWS), .CNT_W(CW)) dut_s (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .len_i       (len),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_s),
        .product_i   (product),
        .out_valid_o (out_valid_s),
        .out_ready_i (out_ready),
        .result_o    (result_s),
        .busy_o      (busy_s),
        .overflow_o  (overflow_s)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact add in 128 bits, then wrap or clamp to w bits.
    function automatic void mdl_add(input int w, input logic signed [127:0] p,
                                    inout logic signed [127:0] acc, inout logic ovf);
        logic signed [127:0] lim, s;
        lim = 128'sd1 <<< (w - 1);
        s   = acc + p;
        if (s >= lim || s < -lim) begin
            ovf = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
            s = (s >= lim) ? lim - 128'sd1 : -lim;
`else
            s = s & ((lim <<< 1) - 128'sd1);
            if (s >= lim) s = s - (lim <<< 1);
`endif
        end
        acc = s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int unsigned n);
        start = 1'b1;
        len   = CW'(n);
        step();
        start = 1'b0;
        m_acc = '0; m_acc_s = '0; m_ovf = 1'b0; m_ovf_s = 1'b0;
        check("busy_after_start", {127'b0, busy}, 128'd1);
    endtask

    task automatic feed(input logic signed [63:0] p, input int gap);
        logic signed [127:0] pe;
        in_valid = 1'b0;
        repeat (gap) begin
            step();
            check("in_ready_stall", {127'b0, in_ready}, 128'd1);
        end
        in_valid = 1'b1;
        product  = p;
        check("in_ready_run", {127'b0, in_ready}, 128'd1);
        step();
        in_valid = 1'b0;
        pe = p;
        mdl_add(AW, pe, m_acc, m_ovf);
        mdl_add(AWS, pe, m_acc_s, m_ovf_s);
    endtask

    task automatic push_exp();
        exp_t e;
        e.r  = m_acc[AW-1:0];
        e.o  = m_ovf;
        e.rs = m_acc_s[AWS-1:0];
        e.os = m_ovf_s;
        exp_q.push_back(e);
    endtask

    // Called in the cycle out_valid must first be high; holds off ready for `hold` cycles.
    task automatic drain(input int hold);
        exp_t e;
        check("sb_has_entry", {127'b0, exp_q.size() != 0}, 128'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        out_ready = 1'b0;
        repeat (hold) begin
            check("hold_out_valid", {127'b0, out_valid}, 128'd1);
            check("hold_in_ready", {127'b0, in_ready}, 128'd0);
            check("hold_result", {56'b0, result}, {56'b0, e.r});
            step();
        end
        out_ready = 1'b1;
        check("out_valid", {127'b0, out_valid}, 128'd1);
        check("result", {56'b0, result}, {56'b0, e.r});
        check("overflow", {127'b0, overflow}, {127'b0, e.o});
        check("out_valid_s", {127'b0, out_valid_s}, 128'd1);
        check("result_s", {62'b0, result_s}, {62'b0, e.rs});
        check("overflow_s", {127'b0, overflow_s}, {127'b0, e.os});
        step();
        out_ready = 1'b0;
        check("idle_out_valid", {127'b0, out_valid}, 128'd0);
        check("idle_busy", {127'b0, busy}, 128'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; clear = 1'b0;
        in_valid = 1'b0; product = '0; out_ready = 1'b0;
        m_acc = '0; m_acc_s = '0; m_ovf = 1'b0; m_ovf_s = 1'b0;
        #12;
        check("rst_in_ready", {127'b0, in_ready}, 128'd0);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_result", {56'b0, result}, 128'd0);
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_overflow", {127'b0, overflow}, 128'd0);
        reset = 1'b0;
        step();

        // Signed mix, back-to-back products.
        start_burst(4);
        feed(64'sd30, 0);
        feed(64'sd28, 0);
        feed(-64'sd40, 0);
        feed(-64'sd250, 0);
        push_exp();
        check("mix_model", {56'b0, exp_q[0].r}, {56'b0, -72'sd232});
        drain(0);

        // Input stalls and output backpressure.
        start_burst(3);
        feed(64'sd99, 0);
        feed(64'sd0, 2);
        feed(64'sd736, 2);
        push_exp();
        drain(5);

        // Zero length, with start re-pulsed during HOLD.
        start = 1'b1; len = '0;
        step();
        m_acc = '0; m_acc_s = '0; m_ovf = 1'b0; m_ovf_s = 1'b0;
        start = 1'b1; len = CW'(2);
        check("zl_out_valid", {127'b0, out_valid}, 128'd1);
        check("zl_result", {56'b0, result}, 128'd0);
        step();
        start = 1'b0;
        check("zl_start_ignored", {127'b0, out_valid}, 128'd1);
        push_exp();
        drain(1);
        step();
        check("zl_stays_idle", {127'b0, busy}, 128'd0);

        // clear beats a product handshake.
        start_burst(4);
        feed(64'sd10, 0);
        feed(64'sd20, 0);
        in_valid = 1'b1; clear = 1'b1; product = 64'd30;
        step();
        in_valid = 1'b0; clear = 1'b0;
        check("clr_busy", {127'b0, busy}, 128'd0);
        check("clr_in_ready", {127'b0, in_ready}, 128'd0);
        check("clr_result", {56'b0, result}, 128'd0);
        repeat (3) step();
        check("clr_no_out_valid", {127'b0, out_valid}, 128'd0);
        start_burst(1);
        feed(64'sd5, 0);
        push_exp();
        drain(0);

        // Asynchronous reset mid-burst.
        start_burst(3);
        feed(-64'sd77, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {127'b0, busy}, 128'd0);
        check("mid_rst_in_ready", {127'b0, in_ready}, 128'd0);
        check("mid_rst_result", {56'b0, result}, 128'd0);
        check("mid_rst_out_valid", {127'b0, out_valid}, 128'd0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_idle", {127'b0, busy}, 128'd0);

        // Long burst of max positive products; the 66-bit twin overflows.
        start_burst(255);
        for (int i = 0; i < 255; i++) feed(64'sh7FFF_FFFF_FFFF_FFFF, 0);
        push_exp();
        drain(2);

        // Negative overflow on the narrow twin.
        start_burst(6);
        for (int i = 0; i < 6; i++) feed(64'sh8000_0000_0000_0000, 0);
        push_exp();
        drain(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
